// File: rtl/move_search_ctrl.sv
// Placement-search sequencer: sweeps every (rotation, column) candidate through
// the board simulator, scores each returned board and keeps the best legal one.
module move_search_ctrl #(
    parameter int NUM_COL = 10,
    parameter int NUM_ROT = 4,
    parameter int TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [3:0]   piece,
    input  logic [199:0] board,
    output logic         busy,
    output logic         done,
    output logic         best_valid,
    output logic [3:0]   best_col,
    output logic [1:0]   best_rot,
    output logic [7:0]   best_score,
    output logic [3:0]   sim_block,
    output logic [3:0]   sim_col,
    output logic [1:0]   sim_rotation,
    output logic [199:0] sim_board,
    output logic         sim_request,
    input  logic         sim_valid,
    input  logic [199:0] sim_next_board,
    input  logic         sim_ready
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_SCORE, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [3:0]     col_q, col_d;
    logic [1:0]     rot_q, rot_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           cap_valid_q, cap_valid_d;
    logic [199:0]   cap_board_q, cap_board_d;
    logic [3:0]     blk_q, blk_d;
    logic [199:0]   brd_q, brd_d;
    logic           best_valid_q, best_valid_d;
    logic [3:0]     best_col_q, best_col_d;
    logic [1:0]     best_rot_q, best_rot_d;
    logic [7:0]     best_score_q, best_score_d;

    logic           last_cand, tmo_expired;
    logic [4:0]     full_cnt, empty_cnt;
    logic           top_run;
    logic [7:0]     score;

    assign last_cand   = (rot_q == 2'(NUM_ROT - 1)) && (col_q == 4'(NUM_COL - 1));
    assign tmo_expired = (tmo_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            rot_q        <= '0;
            tmo_q        <= '0;
            cap_valid_q  <= 1'b0;
            cap_board_q  <= '0;
            blk_q        <= '0;
            brd_q        <= '0;
            best_valid_q <= 1'b0;
            best_col_q   <= '0;
            best_rot_q   <= '0;
            best_score_q <= '0;
        end else begin
            col_q        <= col_d;
            rot_q        <= rot_d;
            tmo_q        <= tmo_d;
            cap_valid_q  <= cap_valid_d;
            cap_board_q  <= cap_board_d;
            blk_q        <= blk_d;
            brd_q        <= brd_d;
            best_valid_q <= best_valid_d;
            best_col_q   <= best_col_d;
            best_rot_q   <= best_rot_d;
            best_score_q <= best_score_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (sim_ready || tmo_expired) state_d = S_SCORE;
            S_SCORE: state_d = last_cand ? S_DONE : S_ISSUE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Full rows anywhere, empty rows only as an unbroken run from the top (row 0).
    always_comb begin
        full_cnt  = '0;
        empty_cnt = '0;
        top_run   = 1'b1;
        for (int r = 0; r < 20; r++) begin
            if (cap_board_q[r*10 +: 10] == 10'h3FF) full_cnt = full_cnt + 5'd1;
            if (top_run && cap_board_q[r*10 +: 10] == 10'h000) empty_cnt = empty_cnt + 5'd1;
            else top_run = 1'b0;
        end
        score = {full_cnt[3:0], 4'b0000} + {3'b000, empty_cnt};
    end

    always_comb begin
        col_d        = col_q;
        rot_d        = rot_q;
        tmo_d        = tmo_q;
        cap_valid_d  = cap_valid_q;
        cap_board_d  = cap_board_q;
        blk_d        = blk_q;
        brd_d        = brd_q;
        best_valid_d = best_valid_q;
        best_col_d   = best_col_q;
        best_rot_d   = best_rot_q;
        best_score_d = best_score_q;
        case (state_q)
            S_IDLE: if (start) begin
                blk_d        = piece;
                brd_d        = board;
                col_d        = '0;
                rot_d        = '0;
                best_valid_d = 1'b0;
                best_col_d   = '0;
                best_rot_d   = '0;
                best_score_d = '0;
            end
            S_ISSUE: tmo_d = '0;
            S_WAIT: begin
                if (sim_ready) begin
                    cap_valid_d = sim_valid;
                    cap_board_d = sim_next_board;
                end else if (tmo_expired) begin
                    cap_valid_d = 1'b0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_SCORE: begin
                // Strict compare keeps the earliest candidate on a tie.
                if (cap_valid_q && (!best_valid_q || score > best_score_q)) begin
                    best_valid_d = 1'b1;
                    best_col_d   = col_q;
                    best_rot_d   = rot_q;
                    best_score_d = score;
                end
                if (last_cand) begin
                    col_d = '0;
                    rot_d = '0;
                end else if (col_q == 4'(NUM_COL - 1)) begin
                    col_d = '0;
                    rot_d = rot_q + 2'd1;
                end else begin
                    col_d = col_q + 4'd1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        sim_request  = (state_q == S_ISSUE);
        busy         = (state_q != S_IDLE);
        done         = (state_q == S_DONE);
        best_valid   = best_valid_q;
        best_col     = best_col_q;
        best_rot     = best_rot_q;
        best_score   = best_score_q;
        sim_block    = blk_q;
        sim_col      = col_q;
        sim_rotation = rot_q;
        sim_board    = brd_q;
    end
endmodule

// File: tb/tb_move_search_ctrl.sv
// Bench for move_search_ctrl: behavioural board simulator, vector table of
// searches with queued expectations, plus restart and mid-search reset sequences.
module tb_move_search_ctrl;
    localparam int M_NORM = 0, M_INV = 1, M_NORDY = 2, M_SCRIPT = 3;

    typedef struct {
        logic [3:0]   piece;
        logic [199:0] brd;
        int           mode;
        int           exp_cyc;
        logic         ev;
        logic [3:0]   ec;
        logic [1:0]   er;
        logic [7:0]   es;
    } vec_t;

    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [3:0]   piece = '0;
    logic [199:0] board = '0;
    logic         busy, done, best_valid, sim_request;
    logic [3:0]   best_col, sim_block, sim_col;
    logic [1:0]   best_rot, sim_rotation;
    logic [7:0]   best_score;
    logic [199:0] sim_board;
    logic         sim_valid = 1'b0, sim_ready = 1'b0;
    logic [199:0] sim_next_board = '0;

    int errors = 0, checks = 0, mode = M_NORM;
    vec_t vecs[5];
    vec_t sb_q[$];

    move_search_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .piece(piece), .board(board),
        .busy(busy), .done(done), .best_valid(best_valid), .best_col(best_col),
        .best_rot(best_rot), .best_score(best_score), .sim_block(sim_block),
        .sim_col(sim_col), .sim_rotation(sim_rotation), .sim_board(sim_board),
        .sim_request(sim_request), .sim_valid(sim_valid),
        .sim_next_board(sim_next_board), .sim_ready(sim_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Rectangle-drop board simulator: O is 2x2, I is 4x1 / 1x4 by rotation parity.
    function automatic logic [200:0] sim_fn(input int md, input logic [3:0] pc,
                                            input logic [199:0] b, input logic [1:0] rot,
                                            input logic [3:0] col);
        int w, h, land;
        logic [9:0] m;
        logic [199:0] nb;
        logic fit;
        if (md == M_INV) return {1'b0, 200'b0};
        if (md == M_SCRIPT) begin
            nb = '0;
            nb[int'(col)*10 +: 10] = 10'h001;
            if (rot == 2'd2) nb[190 +: 10] = 10'h3FF;
            return {(col != 4'd9), nb};
        end
        if (pc == 4'd1) begin w = 2; h = 2; end
        else if (rot[0]) begin w = 1; h = 4; end
        else begin w = 4; h = 1; end
        if (int'(col) + w > 10) return {1'b0, b};
        m = 10'(((1 << w) - 1) << int'(col));
        land = -1;
        for (int y = 0; y <= 20 - h; y++) begin
            fit = 1'b1;
            for (int k = 0; k < h; k++)
                if ((b[(y+k)*10 +: 10] & m) != 10'h0) fit = 1'b0;
            if (fit) land = y;
            else break;
        end
        if (land < 0) return {1'b0, b};
        nb = b;
        for (int k = 0; k < h; k++) nb[(land+k)*10 +: 10] = nb[(land+k)*10 +: 10] | m;
        return {1'b1, nb};
    endfunction

    logic       req_seen = 1'b0, prev_req = 1'b0;
    logic [3:0] req_col = '0, exp_col = '0;
    logic [1:0] req_rot = '0, exp_rot = '0;

    // Request monitor: candidate order and request spacing.
    always @(negedge clk) begin
        if (!rst_n || (start && !busy)) begin
            exp_col = '0;
            exp_rot = '0;
        end else if (sim_request) begin
            chk("req_order", {26'd0, sim_rotation, sim_col}, {26'd0, exp_rot, exp_col});
            if (exp_col == 4'd9) begin exp_col = '0; exp_rot = exp_rot + 2'd1; end
            else exp_col = exp_col + 4'd1;
        end
        if (sim_request && prev_req) chk("req_back_to_back", 32'd1, 32'd0);
        prev_req = sim_request;
        req_seen = sim_request && rst_n;
        req_col  = sim_col;
        req_rot  = sim_rotation;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sim_ready      <= 1'b0;
            sim_valid      <= 1'b0;
            sim_next_board <= '0;
        end else begin
            sim_ready <= 1'b0;
            if (req_seen && mode != M_NORDY) begin
                sim_ready <= 1'b1;
                {sim_valid, sim_next_board} <= sim_fn(mode, sim_block, sim_board, req_rot, req_col);
            end
        end
    end

    task automatic run_search(input vec_t v, input int restart_at);
        int cyc;
        bit got;
        vec_t e;
        piece = v.piece;
        board = v.brd;
        mode  = v.mode;
        sb_q.push_back(v);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        piece = 4'hF;
        board = {200{1'b1}};
        cyc = 1;
        got = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        while (cyc < 1000) begin
            start = (cyc == restart_at);
            if (done) begin got = 1'b1; break; end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        e = sb_q.pop_front();
        if (!got) begin
            chk("done_timeout", 32'd0, 32'd1);
        end else begin
            chk("done_cycle", cyc, e.exp_cyc);
            chk("best_valid", {31'd0, best_valid}, {31'd0, e.ev});
            chk("best_col", {28'd0, best_col}, {28'd0, e.ec});
            chk("best_rot", {30'd0, best_rot}, {30'd0, e.er});
            chk("best_score", {24'd0, best_score}, {24'd0, e.es});
            chk("sim_block_held", {28'd0, sim_block}, {28'd0, e.piece});
            @(posedge clk); #1;
            chk("done_one_cycle", {31'd0, done}, 32'd0);
            chk("idle_after_done", {31'd0, busy}, 32'd0);
            repeat (3) @(posedge clk);
            #1 chk("best_hold", {24'd0, best_score}, {24'd0, e.es});
        end
    endtask

    initial begin
        int cyc;
        logic [199:0] b1;
        b1 = '0;
        b1[190 +: 10] = 10'h3F0;
        vecs[0] = '{4'd1, 200'd0, M_NORM,   121, 1'b1, 4'd0, 2'd0, 8'd18};
        vecs[1] = '{4'd7, b1,     M_NORM,   121, 1'b1, 4'd0, 2'd0, 8'd35};
        vecs[2] = '{4'd1, 200'd0, M_INV,    121, 1'b0, 4'd0, 2'd0, 8'd0};
        vecs[3] = '{4'd1, 200'd0, M_NORDY,  681, 1'b0, 4'd0, 2'd0, 8'd0};
        vecs[4] = '{4'd7, 200'd0, M_SCRIPT, 121, 1'b1, 4'd8, 2'd2, 8'd24};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_req", {31'd0, sim_request}, 32'd0);
        chk("rst_best", {17'd0, best_valid, best_col, best_rot, best_score}, 32'd0);
        chk("rst_sim_fields", {22'd0, sim_block, sim_col, sim_rotation}, 32'd0);
        chk("rst_sim_board", {31'd0, (sim_board == '0)}, 32'd1);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_search(vecs[i], -1);

        // Second start mid-search must be dropped.
        run_search(vecs[0], 50);

        // Reset during an issue cycle aborts the search.
        piece = 4'd7; board = b1; mode = M_NORM;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 1;
        while (cyc < 80 && !(cyc >= 30 && sim_request)) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("req_before_reset", {31'd0, sim_request}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("reset_req_async", {31'd0, sim_request}, 32'd0);
        chk("reset_busy_async", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_best_clear", {17'd0, best_valid, best_col, best_rot, best_score}, 32'd0);
        cyc = 0;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk); #1;
            if (done || busy) cyc++;
        end
        chk("no_done_after_reset", cyc, 32'd0);
        run_search(vecs[1], -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
